framebuffer_reader: RTL and testbench
=====================================

FRAMEBUFFER_READER -- requirements
Module: framebuffer_reader

Interface
REQ-001 Parameter W, default 8: width of each RAM word and of each output beat.
REQ-002 Parameter L, default 32: number of RAM words per frame; the address width is $clog2(L).
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 rst  input  1  Reset, asynchronous and active-high.
REQ-005 start  input  1  Request one frame read; sampled only in IDLE.
REQ-006 loop  input  1  When high at last-beat acceptance, the next frame starts immediately.
REQ-007 busy  output  1  High in any state other than IDLE.
REQ-008 done  output  1  One-cycle pulse when the final beat of a frame is accepted and loop=0.
REQ-009 rd_addr  output  $clog2(L)  Read address driven to the synchronous RAM.
REQ-010 rd_data  input  W  RAM read data, valid exactly one cycle after the address is presented.
REQ-011 out_data  output  W  Stream data.
REQ-012 out_valid  output  1  Stream data valid.
REQ-013 out_ready  input  1  Downstream accept; a beat transfers when out_valid && out_ready.
REQ-014 out_last  output  1  High with the beat read from address L-1.

Function
REQ-015 States: IDLE, FETCH, DRAIN.
- IDLE->FETCH on start=1.
- FETCH->DRAIN after the read of address L-1 is issued.
- DRAIN->IDLE when the last beat is accepted with loop=0.
- DRAIN->FETCH when the last beat is accepted with loop=1, and the address counter resets to 0.
REQ-016 A read is issued in a cycle when the state is FETCH and (buffered beats + reads in flight) < 2; an issued read increments the address counter.
REQ-017 rd_addr shall equal the address counter combinationally, so an issued read's data is captured one cycle later.
REQ-018 Captured data enters a 2-entry FIFO with a last tag; out_data, out_valid and out_last present the FIFO head.
REQ-019 out_data and out_last shall stay stable while out_valid=1 and out_ready=0.
REQ-020 Beats leave in strictly ascending address order 0..L-1; no beat is dropped or duplicated under any out_ready pattern.
REQ-021 With out_ready held at 1, the first beat appears 2 cycles after start is sampled, and throughput is one beat per cycle.
REQ-022 A capture and a pop in the same cycle leave the FIFO occupancy unchanged.
- The FIFO shall never overflow; the credit rule in REQ-016 guarantees this.
REQ-023 start is ignored while busy=1.
REQ-024 When loop=1, the first beat of the next frame may follow the last beat of the previous frame with no bubble.
REQ-025 When L=1, every beat has out_last=1.
REQ-026 The address counter shall not wrap past L-1 within a frame.

Reset
REQ-027 Asserting rst at any time, including mid-frame, immediately forces:
- state=IDLE, address counter=0, FIFO empty, in-flight flag cleared;
- busy=0, done=0, out_valid=0, out_last=0, rd_addr=0, out_data=0.
REQ-028 After rst deasserts, no beat from an interrupted frame shall ever be emitted; the next start begins at address 0.

Verification
REQ-029 RAM preloaded with word[i]=i+1, L=32, W=8; start pulse; out_ready=1.
- Beats 1..32 on consecutive cycles, the first 2 cycles after start.
- out_last=1 only with 32.
- done pulses on the same cycle the beat 32 is accepted; busy falls the next cycle.
REQ-030 Same preload; out_ready toggles 1,0,1,0.
- All 32 values are received exactly once, in order.
- out_data holds while stalled.
- The FIFO never exceeds 2 entries.
REQ-031 out_ready=0 for 10 cycles after start.
- out_valid=1 with data 1 held throughout.
- At most 2 reads are issued.
- After releasing out_ready, the sequence resumes at 1,2,3.
REQ-032 loop=1 with out_ready=1.
- After beat 32 (out_last=1), beat 1 follows on the next cycle.
- done stays 0 until loop is dropped; done pulses at the following last beat.
REQ-033 Assert rst after beat 10 is accepted, then start again.
- Outputs are zero during rst.
- The new frame begins with value 1.
- No beat 11 from the aborted frame appears.
REQ-034 Pulse start again during the frame: it is ignored, and exactly 32 beats are followed by one done pulse.

Source files
------------

// File: rtl/framebuffer_reader.sv
// framebuffer_reader: streams L words from a synchronous RAM through a 2-entry FIFO as a valid/ready beat stream.
// With loop=1 the next frame is prefetched during DRAIN, so a looping stream has no gap between frames.
module framebuffer_reader #(
  parameter int W = 8,
  parameter int L = 32,
  localparam int AW = (L > 1) ? $clog2(L) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          loop,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam logic [AW-1:0] LAST = AW'(L - 1);
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic inf_q, inf_last_q, pf_q, pf_d;
  logic [1:0] cnt_q, cnt_d, tag_q, room;
  logic rp_q, wp_q;
  logic [W-1:0] mem_q [2];
  logic issue, issue_last, pop, push, last_acc, flush;
  // The slot freed by this cycle's pop counts as credit, so a stream with out_ready held high runs at one beat per cycle.
  assign room = cnt_q - 2'(pop) + 2'(inf_q);
  assign issue = (room < 2'd2) && (state_q == FETCH || (state_q == DRAIN && loop && !pf_q));
  assign issue_last = issue && addr_q == LAST;
  assign out_valid = cnt_q != 2'd0;
  assign pop = out_valid && out_ready;
  assign last_acc = pop && tag_q[rp_q] && state_q == DRAIN;
  // Ending a frame discards any prefetched beats of the next frame.
  assign flush = last_acc && !loop;
  assign push = inf_q && !flush;
  assign cnt_d = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
  assign done = flush;
  assign busy = state_q != IDLE;
  assign rd_addr = addr_q;
  assign out_data = out_valid ? mem_q[rp_q] : '0;
  assign out_last = out_valid && tag_q[rp_q];
  always_comb begin
    state_d = state_q;
    addr_d = issue ? (issue_last ? '0 : addr_q + 1'b1) : addr_q;
    pf_d = pf_q;
    case (state_q)
      IDLE: state_d = start ? FETCH : IDLE;
      FETCH: state_d = issue_last ? DRAIN : FETCH;
      DRAIN: begin
        pf_d = pf_q || issue_last;
        if (last_acc) begin
          state_d = !loop ? IDLE : (pf_q || issue_last) ? DRAIN : FETCH;
          pf_d = 1'b0;
          addr_d = loop ? addr_d : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      inf_q <= 1'b0;
      inf_last_q <= 1'b0;
      pf_q <= 1'b0;
      cnt_q <= 2'd0;
      rp_q <= 1'b0;
      wp_q <= 1'b0;
      tag_q <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      inf_q <= issue;
      inf_last_q <= issue_last;
      pf_q <= pf_d;
      cnt_q <= cnt_d;
      rp_q <= flush ? 1'b0 : rp_q ^ pop;
      wp_q <= flush ? 1'b0 : wp_q ^ push;
      if (push) tag_q[wp_q] <= inf_last_q;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= rd_data;
  end
endmodule

// File: tb/tb_framebuffer_reader.sv
// tb_framebuffer_reader: directed and randomized frame reads checked against a queue of expected word indices.
module tb_framebuffer_reader;
  localparam int W = 8, L = 32;
  logic clk = 1'b0, rst, start, loop, busy, done, out_valid, out_ready, out_last;
  logic [4:0] rd_addr;
  logic [W-1:0] rd_data, out_data, held_d;
  logic held_l;
  logic [W-1:0] ram [L];
  int checks = 0, errors = 0, cyc = 0, beats = 0, lasts = 0, dones = 0, first_cyc = 0, last_cyc = 0;
  int exp_q[$];
  bit chk_nobub = 0, nobub = 0, stall_prev = 0;

  framebuffer_reader #(.W(W), .L(L)) dut (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    rd_data <= ram[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_data", out_data, 0);
  endtask

  task automatic load(input bit rnd);
    for (int i = 0; i < L; i++) ram[i] = rnd ? W'($urandom) : W'(i + 1);
  endtask

  task automatic go();
    for (int i = 0; i < L; i++) exp_q.push_back(i);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: ready unchanged, 1: toggling with a spurious start, 2: random ready
  task automatic run_to_done(input int lim, input int mode, input int nbeats);
    int d0 = dones, b0 = beats, n = 0;
    while (dones == d0 && n < lim) begin
      @(posedge clk); #1;
      n++;
      out_ready = mode == 1 ? ~out_ready : mode == 2 ? ($urandom % 4 != 0) : out_ready;
      start = mode == 1 && n == 15;
    end
    start = 1'b0;
    chk("done_pulse", dones - d0, 1);
    chk("beat_count", beats - b0, nbeats);
    chk("idle_busy", busy, 0);
    chk("drained", exp_q.size(), 0);
  endtask

  // Every accepted beat must match the head of the expected-index queue.
  always @(negedge clk) begin
    int idx;
    if (rst) begin
      stall_prev = 0;
      nobub = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_d);
        chk("hold_last", out_last, held_l);
      end
      if (nobub) chk("loop_nobubble", out_valid, 1);
      nobub = 0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          idx = exp_q.pop_front();
          chk("beat_data", out_data, ram[idx]);
          chk("beat_last", out_last, idx == L - 1);
          chk("done_at_last", done, idx == L - 1 && !loop);
          beats++;
          if (idx == 0) first_cyc = cyc;
          if (idx == L - 1) begin
            last_cyc = cyc;
            lasts++;
            if (loop) begin
              for (int i = 0; i < L; i++) exp_q.push_back(i);
              nobub = chk_nobub;
            end
          end
        end
      end else chk("done_quiet", done, 0);
      if (done === 1'b1) dones++;
      stall_prev = out_valid === 1'b1 && out_ready === 1'b0;
      held_d = out_data;
      held_l = out_last;
    end
  end

  initial begin
    int l0, b0, n;
    rst = 1'b1; start = 1'b0; loop = 1'b0; out_ready = 1'b1;
    load(0);
    #1 chk_zero();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // full-rate frame: first beat two edges after start is sampled
    go();
    chk("start_busy", busy, 1);
    chk("lat_valid0", out_valid, 0);
    @(posedge clk); #1 chk("lat_valid1", out_valid, 0);
    @(posedge clk); #1 chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 1);
    run_to_done(100, 0, L);
    chk("span", last_cyc - first_cyc, L - 1);
    // toggling ready with an ignored start mid-frame
    go();
    run_to_done(200, 1, L);
    // long stall right after start
    out_ready = 1'b0;
    go();
    repeat (10) @(posedge clk);
    #1 chk("stall_valid", out_valid, 1);
    chk("stall_data", out_data, 1);
    chk("stall_reads", rd_addr, 2);
    out_ready = 1'b1;
    run_to_done(100, 0, L);
    // looping frames, then drop loop
    loop = 1'b1; chk_nobub = 1'b1; l0 = lasts; n = 0;
    go();
    while (lasts < l0 + 2 && n < 200) begin
      @(posedge clk); #1 n++;
    end
    chk("loop_lasts", lasts - l0, 2);
    loop = 1'b0;
    run_to_done(100, 0, L);
    chk("loop_total", lasts - l0, 3);
    chk_nobub = 1'b0;
    // reset after beat 10, then a fresh frame
    b0 = beats; n = 0;
    go();
    while (beats < b0 + 10 && n < 100) begin
      @(posedge clk); #1 n++;
    end
    chk("pre_rst_beats", beats - b0, 10);
    rst = 1'b1;
    exp_q.delete();
    #1 chk_zero();
    repeat (2) @(posedge clk);
    #1 chk_zero();
    rst = 1'b0;
    go();
    run_to_done(100, 0, L);
    // random contents with random backpressure
    load(1);
    go();
    run_to_done(600, 2, L);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
